// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper: button conditioning, seconds prescaler and MM:SS counter.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | cleared; minutes, seconds and prescaler held at zero
// S_RUNNING | prescaler advancing, seconds/minutes counting
// S_PAUSED  | prescaler and counters frozen, fractional second kept
module stopwatch_timekeeper #(
  parameter int TICK_COUNT      = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       rollover
);

  localparam int PW = $clog2(TICK_COUNT);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
  localparam logic [DW-1:0] DEB_LIMIT  = DW'(DEBOUNCE_CYCLES);
  localparam logic [5:0]    LAST_59    = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  // Bit 0 is start/stop, bit 1 is clear; both paths are identical.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q, deb_prev_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic          ss_ev, clr_ev;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic          running_q, running_d;
  logic          rollover_q, rollover_d;
  logic          tick;

  assign btn_raw = {btn_clear, btn_start_stop};

  // Synchronise, then accept a level change only after DEBOUNCE_CYCLES+1
  // consecutive differing samples; any matching sample restarts the count.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LIMIT) begin
          deb_d[i]     = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Press events fire on the rising edge of the debounced level only.
  assign ss_ev  = deb_q[0] & ~deb_prev_q[0];
  assign clr_ev = deb_q[1] & ~deb_prev_q[1];

  // Next-state and counter logic; clear beats start/stop only when paused.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    rollover_d = 1'b0;
    tick       = (presc_q == PRESC_LAST);
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        sec_d   = '0;
        min_d   = '0;
        if (ss_ev) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (tick) begin
          presc_d = '0;
          if (sec_q == LAST_59) begin
            sec_d = '0;
            if (min_q == LAST_59) begin
              min_d      = '0;
              rollover_d = 1'b1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (ss_ev) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (clr_ev) begin
          state_d = S_IDLE;
          presc_d = '0;
          sec_d   = '0;
          min_d   = '0;
        end else if (ss_ev) begin
          state_d = S_RUNNING;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        sec_d   = '0;
        min_d   = '0;
      end
    endcase
    running_d = (state_d == S_RUNNING);
  end

  // All state registers, synchronous reset with top priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      state_q      <= S_IDLE;
      presc_q      <= '0;
      sec_q        <= '0;
      min_q        <= '0;
      running_q    <= 1'b0;
      rollover_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      state_q      <= state_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      running_q    <= running_d;
      rollover_q   <= rollover_d;
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Directed bench: dut_a (TICK_COUNT=4) for control paths, dut_b (TICK_COUNT=2)
// for the full 59:59 wrap. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that point, so every check sees post-edge values.
module tb_stopwatch_timekeeper;

  logic       clock;
  logic       reset_a, ss_a, clr_a;
  logic       reset_b, ss_b, clr_b;
  logic [5:0] min_a, sec_a, min_b, sec_b;
  logic       run_a, roll_a, run_b, roll_b;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_timekeeper #(.TICK_COUNT(4), .DEBOUNCE_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset_a), .btn_start_stop(ss_a), .btn_clear(clr_a),
    .minutes(min_a), .seconds(sec_a), .running(run_a), .rollover(roll_a)
  );

  stopwatch_timekeeper #(.TICK_COUNT(2), .DEBOUNCE_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset_b), .btn_start_stop(ss_b), .btn_clear(clr_b),
    .minutes(min_b), .seconds(sec_b), .running(run_b), .rollover(roll_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold a button long enough to produce its event (event lands on the 6th
  // edge after the call), then release. 0=a start, 1=a clear, 3=b start.
  task automatic press(input int which);
    case (which)
      0: ss_a = 1'b1;
      1: clr_a = 1'b1;
      default: ss_b = 1'b1;
    endcase
    tick(6);
    ss_a = 1'b0; clr_a = 1'b0; ss_b = 1'b0;
  endtask

  task automatic test_reset;
    reset_a = 1'b1; reset_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ss_a = i[0]; clr_a = ~i[0]; ss_b = ~i[0]; clr_b = i[0];
      tick(1);
      n_checks++;
      if ({min_a, sec_a, run_a, roll_a} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_hold_a: got %0d:%0d run=%0b roll=%0b, want 0:0 run=0 roll=0",
                 min_a, sec_a, run_a, roll_a);
      end
      n_checks++;
      if ({min_b, sec_b, run_b, roll_b} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_hold_b: got %0d:%0d run=%0b roll=%0b, want 0:0 run=0 roll=0",
                 min_b, sec_b, run_b, roll_b);
      end
    end
    ss_a = 1'b0; clr_a = 1'b0; ss_b = 1'b0; clr_b = 1'b0;
    tick(1);
    reset_a = 1'b0; reset_b = 1'b0;
    tick(10);
    n_checks++;
    if ({run_a, sec_a} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got run=%0b sec=%0d, want run=0 sec=0", run_a, sec_a);
    end
  endtask

  task automatic test_bounce;
    ss_a = 1'b1; tick(1); ss_a = 1'b0;
    tick(8);
    n_checks++;
    if (run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_1cyc: got run=%0b, want 0", run_a);
    end
    ss_a = 1'b1; tick(2); ss_a = 1'b0;
    tick(8);
    n_checks++;
    if (run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_2cyc: got run=%0b, want 0", run_a);
    end
  endtask

  task automatic test_start_latency;
    ss_a = 1'b1;
    tick(5);
    n_checks++;
    if (run_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early: got run=%0b, want 0", run_a);
    end
    tick(1);
    n_checks++;
    if (run_a !== 1'b1 || sec_a !== 6'd0) begin
      n_fail++;
      $display("FAIL start_edge: got run=%0b sec=%0d, want run=1 sec=0", run_a, sec_a);
    end
    tick(3);
    n_checks++;
    if (sec_a !== 6'd0) begin
      n_fail++;
      $display("FAIL first_sec_early: got sec=%0d, want 0", sec_a);
    end
    tick(1);
    n_checks++;
    if (sec_a !== 6'd1) begin
      n_fail++;
      $display("FAIL first_sec: got sec=%0d, want 1", sec_a);
    end
    tick(8);
    n_checks++;
    if (sec_a !== 6'd3 || run_a !== 1'b1) begin
      n_fail++;
      $display("FAIL held_third_sec: got sec=%0d run=%0b, want sec=3 run=1", sec_a, run_a);
    end
    ss_a = 1'b0;
  endtask

  task automatic test_pause_resume;
    reset_a = 1'b1; tick(1); reset_a = 1'b0;
    n_checks++;
    if ({min_a, sec_a, run_a, roll_a} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_pulse: got %0d:%0d run=%0b, want 0:0 run=0", min_a, sec_a, run_a);
    end
    press(0);
    tick(4);
    press(0);
    n_checks++;
    if (run_a !== 1'b0 || sec_a !== 6'd2 || min_a !== 6'd0) begin
      n_fail++;
      $display("FAIL pause_at_2: got %0d:%0d run=%0b, want 0:2 run=0", min_a, sec_a, run_a);
    end
    tick(20);
    n_checks++;
    if (run_a !== 1'b0 || sec_a !== 6'd2) begin
      n_fail++;
      $display("FAIL pause_hold: got sec=%0d run=%0b, want sec=2 run=0", sec_a, run_a);
    end
    press(0);
    n_checks++;
    if (run_a !== 1'b1 || sec_a !== 6'd2) begin
      n_fail++;
      $display("FAIL resume: got sec=%0d run=%0b, want sec=2 run=1", sec_a, run_a);
    end
    tick(1);
    n_checks++;
    if (sec_a !== 6'd2) begin
      n_fail++;
      $display("FAIL resume_frac_early: got sec=%0d, want 2", sec_a);
    end
    tick(1);
    n_checks++;
    if (sec_a !== 6'd3) begin
      n_fail++;
      $display("FAIL resume_frac: got sec=%0d, want 3", sec_a);
    end
  endtask

  task automatic test_clear;
    press(1);
    n_checks++;
    if (run_a !== 1'b1 || sec_a !== 6'd4) begin
      n_fail++;
      $display("FAIL clear_while_running: got sec=%0d run=%0b, want sec=4 run=1", sec_a, run_a);
    end
    tick(6);
    press(0);
    n_checks++;
    if (run_a !== 1'b0 || sec_a !== 6'd7) begin
      n_fail++;
      $display("FAIL pause_at_7: got sec=%0d run=%0b, want sec=7 run=0", sec_a, run_a);
    end
    tick(8);
    ss_a = 1'b1; clr_a = 1'b1;
    tick(5);
    n_checks++;
    if (sec_a !== 6'd7) begin
      n_fail++;
      $display("FAIL both_early: got sec=%0d, want 7", sec_a);
    end
    tick(1);
    n_checks++;
    if ({min_a, sec_a, run_a} !== 13'd0) begin
      n_fail++;
      $display("FAIL both_clear_wins: got %0d:%0d run=%0b, want 0:0 run=0", min_a, sec_a, run_a);
    end
    ss_a = 1'b0; clr_a = 1'b0;
    tick(8);
    press(0);
    tick(3);
    n_checks++;
    if (run_a !== 1'b1 || sec_a !== 6'd0) begin
      n_fail++;
      $display("FAIL after_clear_presc_early: got sec=%0d run=%0b, want sec=0 run=1", sec_a, run_a);
    end
    tick(1);
    n_checks++;
    if (sec_a !== 6'd1) begin
      n_fail++;
      $display("FAIL after_clear_presc: got sec=%0d, want 1", sec_a);
    end
  endtask

  task automatic test_rollover;
    logic [5:0] exp_sec, exp_min;
    logic       exp_roll;
    press(3);
    n_checks++;
    if (run_b !== 1'b1 || sec_b !== 6'd0) begin
      n_fail++;
      $display("FAIL b_start: got sec=%0d run=%0b, want sec=0 run=1", sec_b, run_b);
    end
    for (int t = 1; t <= 3600; t++) begin
      tick(1);
      n_checks++;
      if (roll_b !== 1'b0) begin
        n_fail++;
        $display("FAIL roll_mid t=%0d: got roll=%0b, want 0", t, roll_b);
      end
      tick(1);
      exp_sec  = 6'(t % 60);
      exp_min  = 6'((t / 60) % 60);
      exp_roll = (t == 3600);
      n_checks++;
      if (sec_b !== exp_sec || min_b !== exp_min || roll_b !== exp_roll || run_b !== 1'b1) begin
        n_fail++;
        $display("FAIL count t=%0d: got %0d:%0d roll=%0b run=%0b, want %0d:%0d roll=%0b run=1",
                 t, min_b, sec_b, roll_b, run_b, exp_min, exp_sec, exp_roll);
      end
    end
    tick(1);
    n_checks++;
    if (roll_b !== 1'b0 || run_b !== 1'b1 || {min_b, sec_b} !== 12'd0) begin
      n_fail++;
      $display("FAIL roll_one_cycle: got %0d:%0d roll=%0b run=%0b, want 0:0 roll=0 run=1",
               min_b, sec_b, roll_b, run_b);
    end
  endtask

  task automatic test_reset_midrun;
    tick(5);
    ss_b = 1'b1;
    tick(3);
    reset_b = 1'b1; ss_b = 1'b0;
    tick(1);
    n_checks++;
    if ({min_b, sec_b, run_b, roll_b} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: got %0d:%0d run=%0b roll=%0b, want all 0",
               min_b, sec_b, run_b, roll_b);
    end
    reset_b = 1'b0;
    tick(12);
    n_checks++;
    if (run_b !== 1'b0 || sec_b !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_discard_debounce: got run=%0b sec=%0d, want run=0 sec=0", run_b, sec_b);
    end
  endtask

  initial begin
    reset_a = 1'b1; ss_a = 1'b0; clr_a = 1'b0;
    reset_b = 1'b1; ss_b = 1'b0; clr_b = 1'b0;
    tick(2);
    test_reset();
    test_bounce();
    test_start_latency();
    test_pause_resume();
    test_clear();
    test_rollover();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
